majority_vote_sequencer: RTL and testbench
==========================================

// Module: majority_vote_sequencer
// PURPOSE
//  Shares one registered popcount/majority evaluator between NREQ requesters,
//  each presenting a WIDTH-bit word with a valid/ready handshake.
//  Round-robin arbitration picks one request per transaction. The block
//  returns the one-count, the majority decision and the requester id on a
//  valid/ready result port.
//  Sits between the GPIO/HIP capture logic and the result output pins.
//  Replaces per-channel majority voters with one shared evaluator.
// PARAMETERS
//  NREQ        4   number of requesters (>=2)
//  WIDTH       8   bits per vote word
//  THRESH_DEF  4   reset threshold; majority bit = (popcount > threshold)
//  CW = $clog2(WIDTH+1) and IW = $clog2(NREQ) are localparams, not overridable.
// PORTS
//  gclk        in   1           single clock, rising edge
//  resetn      in   1           asynchronous, active-HIGH reset (1 = reset)
//  req_valid   in   NREQ        per-requester word valid
//  req_data    in   NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
//  req_ready   out  NREQ        one-hot accept strobe
//  cfg_we      in   1           threshold write enable
//  cfg_thresh  in   CW          new threshold value
//  res_valid   out  1           result valid
//  res_ready   in   1           result consumer ready
//  res_bit     out  1           majority decision
//  res_count   out  CW          number of ones in the accepted word
//  res_id      out  IW          index of the granted requester
//  busy        out  1           high in every state except IDLE
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state = IDLE, rr_ptr = 0, thresh_q = THRESH_DEF.
//   - res_valid, res_bit, res_count, res_id, busy and req_ready are all 0.
//  FSM: IDLE -> COUNT -> CMP -> RESP -> IDLE.
//   IDLE:
//    - grant = first i with req_valid[i] = 1, scanning from rr_ptr upward
//      with wrap-around.
//    - req_ready[grant] = 1, driven combinationally, only in IDLE and only
//      when some req_valid is high. All other bits are 0.
//    - Accept edge: capture req_data slice, grant id and thresh_q into the
//      transaction registers. Set rr_ptr = (grant + 1) mod NREQ.
//      Go to COUNT.
//   COUNT: count_q <= popcount(word). Go to CMP.
//   CMP: res_bit <= (count_q > thr_txn); res_count <= count_q;
//        res_id <= id. Go to RESP.
//   RESP:
//    - res_valid = 1; all result outputs held stable until the handshake.
//    - Handshake edge (res_valid & res_ready): res_valid -> 0, go to IDLE.
//  Latency and throughput:
//   - Accept edge E0 -> res_valid high after edge E2.
//   - Minimum spacing is 4 cycles per transaction. The next accept is
//     possible in the cycle after the result handshake.
//  Arithmetic:
//   - popcount is unsigned, CW bits, range 0..WIDTH.
//   - The compare is unsigned. If threshold >= WIDTH, res_bit is always 0.
//  Boundary rules:
//   - cfg_we: thresh_q updates on the edge. An accept on the same edge
//     captures the OLD thresh_q. Writes while busy never affect the
//     in-flight transaction.
//   - req_valid dropped while not granted: no effect. No request is ever
//     lost or duplicated.
//   - req_valid and req_data must hold until req_ready.
//   - res_ready held low: stall indefinitely in RESP. No new accepts.
//   - Only one word is in flight at a time.
//   - Reset asserted mid-transaction: the transaction is discarded.
//     Outputs return to reset values immediately (asynchronously).
// TESTING
//  1. Reset, then req0 = 8'hF8 (5 ones): req_ready[0] pulses; 2 cycles
//     later res_valid = 1, res_count = 5, res_bit = 1, res_id = 0.
//  2. req0 = 8'h0F (4 ones), default threshold -> res_bit = 0, res_count = 4.
//     Repeat with cfg_thresh = 3 -> res_bit = 1.
//  3. All four req_valid held high with res_ready = 1: grants go 0,1,2,3,0
//     with one accept every 4 cycles.
//  4. Hold res_ready = 0 for 10 cycles: res_* stable, busy = 1, req_ready = 0.
//     Raising res_ready completes the handshake and the next grant follows.
//  5. cfg_we on the accept edge with cfg_thresh = 0, word 8'h01: result uses
//     threshold 4 -> res_bit = 0. The next word 8'h01 gives res_bit = 1.
//  6. Assert resetn during CMP: res_valid = 0 immediately and rr_ptr = 0.
//     After release the first request is served normally.

Source files
------------

// File: rtl/majority_vote_sequencer_if.sv
// Request/result bundle for the shared majority evaluator.
// The slave modport is the evaluator side and the master modport is the requester/consumer side.
interface majority_vote_sequencer_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_bit;
  logic [CW-1:0]         res_count;
  logic [IW-1:0]         res_id;

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_bit, res_count, res_id
  );

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_bit, res_count, res_id
  );
endinterface

// File: rtl/majority_vote_sequencer.sv
// One shared popcount/majority evaluator with round-robin arbitration across NREQ requesters.
// Only one word is in flight; a result is held until its handshake completes.
module majority_vote_sequencer #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 8,
  parameter int THRESH_DEF = 4,
  localparam int CW = $clog2(WIDTH + 1),
  localparam int IW = $clog2(NREQ)
) (
  input  logic                            gclk,
  input  logic                            resetn,
  majority_vote_sequencer_if.slave        bus,
  input  logic                            cfg_we,
  input  logic [CW-1:0]                   cfg_thresh,
  output logic                            busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_CMP   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [IW-1:0]   rr_ptr_r;
  logic [IW-1:0]   grant_s;
  logic            any_valid_s;
  logic            accept_s;
  logic [NREQ-1:0] req_ready_s;
  logic [WIDTH-1:0] word_r;
  logic [IW-1:0]   id_r;
  logic [CW-1:0]   thr_txn_r;
  logic [CW-1:0]   thresh_r;
  logic [CW-1:0]   count_r;
  logic            res_valid_r;
  logic            res_bit_r;
  logic [CW-1:0]   res_count_r;
  logic [IW-1:0]   res_id_r;
  logic            busy_r;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] w);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CW'(w[i]);
    end
    return c;
  endfunction

  // Round-robin scan: first valid requester at or after rr_ptr, with wrap-around
  always_comb begin
    int idx;
    idx         = 0;
    any_valid_s = 1'b0;
    grant_s     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ((int'(rr_ptr_r) + k) >= NREQ) ? (int'(rr_ptr_r) + k - NREQ) : (int'(rr_ptr_r) + k);
      if (!any_valid_s && bus.req_valid[idx]) begin
        any_valid_s = 1'b1;
        grant_s     = IW'(idx);
      end else begin
        grant_s     = grant_s;
      end
    end
  end

  assign accept_s = (state_r == ST_IDLE) && any_valid_s;

  // One-hot accept strobe; forced low while reset is held so nothing is offered
  always_comb begin
    req_ready_s = '0;
    if (accept_s && !resetn) begin
      req_ready_s[grant_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Next-state logic of the transaction sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_COUNT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COUNT: state_s = ST_CMP;
      ST_CMP:   state_s = ST_RESP;
      ST_RESP: begin
        if (bus.res_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge gclk or posedge resetn) begin
    if (resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // busy and res_valid are registered copies of the next state, so they track it glitch-free
  always_ff @(posedge gclk or posedge resetn) begin
    if (resetn) begin
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      busy_r      <= (state_s != ST_IDLE);
      res_valid_r <= (state_s == ST_RESP);
    end
  end

  // Threshold register; an accept on the same edge still samples the old value
  always_ff @(posedge gclk or posedge resetn) begin
    if (resetn) begin
      thresh_r <= CW'(THRESH_DEF);
    end else if (cfg_we) begin
      thresh_r <= cfg_thresh;
    end else begin
      thresh_r <= thresh_r;
    end
  end

  // Transaction capture, popcount and compare pipeline
  always_ff @(posedge gclk or posedge resetn) begin
    if (resetn) begin
      rr_ptr_r    <= '0;
      word_r      <= '0;
      id_r        <= '0;
      thr_txn_r   <= '0;
      count_r     <= '0;
      res_bit_r   <= 1'b0;
      res_count_r <= '0;
      res_id_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            word_r    <= bus.req_data[int'(grant_s)*WIDTH +: WIDTH];
            id_r      <= grant_s;
            thr_txn_r <= thresh_r;
            rr_ptr_r  <= (grant_s == IW'(NREQ - 1)) ? '0 : (grant_s + IW'(1));
          end else begin
            rr_ptr_r  <= rr_ptr_r;
          end
        end
        ST_COUNT: begin
          count_r <= popcount(word_r);
        end
        ST_CMP: begin
          // Unsigned compare; a threshold >= WIDTH can never be exceeded
          res_bit_r   <= (count_r > thr_txn_r);
          res_count_r <= count_r;
          res_id_r    <= id_r;
        end
        ST_RESP: begin
          res_bit_r <= res_bit_r;
        end
        default: begin
          rr_ptr_r <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.res_valid = res_valid_r;
  assign bus.res_bit   = res_bit_r;
  assign bus.res_count = res_count_r;
  assign bus.res_id    = res_id_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_majority_vote_sequencer.sv
// Directed self-checking bench for majority_vote_sequencer (NREQ=4, WIDTH=8, threshold 4).
module tb_majority_vote_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_thresh;
  logic       busy;
  int         total = 0;
  int         bad   = 0;

  majority_vote_sequencer_if #(.NREQ(4), .WIDTH(8)) bus ();

  majority_vote_sequencer #(.NREQ(4), .WIDTH(8), .THRESH_DEF(4)) dut (
    .gclk       (clk),
    .resetn     (rst),
    .bus        (bus),
    .cfg_we     (cfg_we),
    .cfg_thresh (cfg_thresh),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one word from requester i, wait for its result; lat = negedges from accept to res_valid (-1 on timeout)
  task automatic do_txn(input int i, input logic [7:0] d, output int lat,
                        output logic [3:0] cnt, output logic b, output logic [1:0] id);
    int k;
    lat = -1;
    cnt = 4'd0;
    b   = 1'b0;
    id  = 2'd0;
    bus.req_valid[i] = 1'b1;
    bus.req_data[i*8 +: 8] = d;
    #1;
    k = 0;
    while (!bus.req_ready[i] && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!bus.req_ready[i]) begin
      bus.req_valid[i] = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req_valid[i] = 1'b0;
    cfg_we = 1'b0;
    k = 1;
    while (!bus.res_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.res_valid) return;
    lat = k;
    cnt = bus.res_count;
    b   = bus.res_bit;
    id  = bus.res_id;
    if (bus.res_ready) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_thresh(input logic [3:0] t);
    cfg_we = 1'b1;
    cfg_thresh = t;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_thresh = 4'd0;
    bus.req_valid = 4'hF;
    bus.req_data = 32'h0;
    bus.res_ready = 1'b1;
    #3;
    total++;
    if ({bus.res_valid, bus.res_bit, bus.res_count, bus.res_id, busy, bus.req_ready} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {bus.res_valid, bus.res_bit, bus.res_count, bus.res_id, busy, bus.req_ready});
    end
    @(negedge clk);
    @(negedge clk);
    bus.req_valid = 4'h0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.res_valid, busy, bus.req_ready} !== 6'd0) begin
      bad++;
      $display("FAIL idle_after_release got=%b want=0", {bus.res_valid, busy, bus.req_ready});
    end
  endtask

  task automatic test_basic();
    bus.req_valid = 4'b0001;
    bus.req_data[7:0] = 8'hF8;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL basic_ready got=%b want=0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    total++;
    if ({bus.req_ready, busy, bus.res_valid} !== 6'b0000_1_0) begin
      bad++; $display("FAIL basic_e0 got=%b want=000010", {bus.req_ready, busy, bus.res_valid});
    end
    @(negedge clk);
    total++;
    if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", bus.res_valid); end
    @(negedge clk);
    total++;
    if ({bus.res_valid, bus.res_count, bus.res_bit, bus.res_id} !== {1'b1, 4'd5, 1'b1, 2'd0}) begin
      bad++; $display("FAIL basic_result got=%b want=%b", {bus.res_valid, bus.res_count, bus.res_bit, bus.res_id}, {1'b1, 4'd5, 1'b1, 2'd0});
    end
    @(negedge clk);
    total++;
    if ({bus.res_valid, busy} !== 2'b00) begin bad++; $display("FAIL basic_handshake got=%b want=00", {bus.res_valid, busy}); end
  endtask

  task automatic test_threshold();
    int lat; logic [3:0] c; logic b; logic [1:0] id;
    do_txn(0, 8'h0F, lat, c, b, id);
    total++;
    if ({lat == 3, c, b, id} !== {1'b1, 4'd4, 1'b0, 2'd0}) begin
      bad++; $display("FAIL thr_default lat=%0d cnt=%0d bit=%0b id=%0d want lat=3 cnt=4 bit=0 id=0", lat, c, b, id);
    end
    write_thresh(4'd3);
    do_txn(0, 8'h0F, lat, c, b, id);
    total++;
    if ({lat == 3, c, b} !== {1'b1, 4'd4, 1'b1}) begin
      bad++; $display("FAIL thr_three lat=%0d cnt=%0d bit=%0b want lat=3 cnt=4 bit=1", lat, c, b);
    end
    write_thresh(4'd4);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_c  [5] = '{4'd1, 4'd2, 4'd3, 4'd8, 4'd1};
    logic       exp_b  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] gv [5];
    int         gc [5];
    logic [3:0] rc [5];
    logic       rb [5];
    logic [1:0] ri [5];
    int ng = 0;
    int nr = 0;
    do_reset();
    bus.req_data = 32'hFF07_0301;
    bus.req_valid = 4'hF;
    for (int c = 0; c < 40 && nr < 5; c++) begin
      #1;
      if (bus.req_ready != 4'h0 && ng < 5) begin gv[ng] = bus.req_ready; gc[ng] = c; ng++; end
      if (bus.res_valid && nr < 5) begin rc[nr] = bus.res_count; rb[nr] = bus.res_bit; ri[nr] = bus.res_id; nr++; end
      @(negedge clk);
    end
    bus.req_valid = 4'h0;
    total++;
    if (ng != 5 || nr != 5) begin bad++; $display("FAIL rr_counts grants=%0d results=%0d want 5 5", ng, nr); end
    for (int k = 0; k < 5 && k < ng && k < nr; k++) begin
      total++;
      if ({gv[k], ri[k], rc[k], rb[k]} !== {exp_oh[k], 2'(k % 4), exp_c[k], exp_b[k]} || gc[k] != 4 * k) begin
        bad++;
        $display("FAIL rr_txn%0d ready=%b id=%0d cnt=%0d bit=%0b cyc=%0d want ready=%b id=%0d cnt=%0d bit=%0b cyc=%0d",
                 k, gv[k], ri[k], rc[k], rb[k], gc[k], exp_oh[k], k % 4, exp_c[k], exp_b[k], 4 * k);
      end
    end
  endtask

  task automatic test_stall();
    int lat; logic [3:0] c; logic b; logic [1:0] id;
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b0100;
    bus.req_data[23:16] = 8'hAA;
    #1;
    total++;
    if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL stall_grant got=%b want=0100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    bus.req_valid[1] = 1'b1;
    bus.req_data[15:8] = 8'hFE;
    for (int k = 0; k < 10; k++) begin
      #1;
      total++;
      if ({bus.res_valid, bus.res_count, bus.res_bit, bus.res_id, busy, bus.req_ready} !== {1'b1, 4'd4, 1'b0, 2'd2, 1'b1, 4'b0000}) begin
        bad++; $display("FAIL stall_hold%0d got=%b want=%b", k,
          {bus.res_valid, bus.res_count, bus.res_bit, bus.res_id, busy, bus.req_ready}, {1'b1, 4'd4, 1'b0, 2'd2, 1'b1, 4'b0000});
      end
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({bus.res_valid, bus.req_ready} !== 5'b0_0010) begin
      bad++; $display("FAIL stall_release got=%b want=00010", {bus.res_valid, bus.req_ready});
    end
    do_txn(1, 8'hFE, lat, c, b, id);
    total++;
    if ({lat == 3, c, b, id} !== {1'b1, 4'd7, 1'b1, 2'd1}) begin
      bad++; $display("FAIL stall_next lat=%0d cnt=%0d bit=%0b id=%0d want lat=3 cnt=7 bit=1 id=1", lat, c, b, id);
    end
  endtask

  task automatic test_cfg_boundaries();
    int lat; logic [3:0] c; logic b; logic [1:0] id;
    cfg_we = 1'b1;
    cfg_thresh = 4'd0;
    do_txn(0, 8'h01, lat, c, b, id);
    total++;
    if ({lat == 3, c, b} !== {1'b1, 4'd1, 1'b0}) begin
      bad++; $display("FAIL cfg_same_edge lat=%0d cnt=%0d bit=%0b want lat=3 cnt=1 bit=0", lat, c, b);
    end
    do_txn(0, 8'h01, lat, c, b, id);
    total++;
    if ({c, b} !== {4'd1, 1'b1}) begin bad++; $display("FAIL cfg_new_thr cnt=%0d bit=%0b want cnt=1 bit=1", c, b); end
    do_txn(0, 8'h00, lat, c, b, id);
    total++;
    if ({c, b} !== {4'd0, 1'b0}) begin bad++; $display("FAIL zero_word cnt=%0d bit=%0b want cnt=0 bit=0", c, b); end
    write_thresh(4'd8);
    do_txn(0, 8'hFF, lat, c, b, id);
    total++;
    if ({c, b} !== {4'd8, 1'b0}) begin bad++; $display("FAIL thr_eq_width cnt=%0d bit=%0b want cnt=8 bit=0", c, b); end
    write_thresh(4'd7);
    do_txn(0, 8'hFF, lat, c, b, id);
    total++;
    if ({c, b} !== {4'd8, 1'b1}) begin bad++; $display("FAIL thr_seven cnt=%0d bit=%0b want cnt=8 bit=1", c, b); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [3:0] c; logic b; logic [1:0] id;
    bus.req_valid = 4'b0001;
    bus.req_data[7:0] = 8'hFF;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_grant got=%b want=0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({bus.res_valid, bus.res_bit, bus.res_count, bus.res_id, busy} !== 9'd0) begin
      bad++; $display("FAIL mid_async got=%b want=0", {bus.res_valid, bus.res_bit, bus.res_count, bus.res_id, busy});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req_data[15:0] = 16'hFF3C;
    bus.req_valid = 4'b0011;
    #1;
    total++;
    if ({bus.res_valid, bus.req_ready} !== 5'b0_0001) begin
      bad++; $display("FAIL mid_rrptr got=%b want=00001", {bus.res_valid, bus.req_ready});
    end
    do_txn(0, 8'h3C, lat, c, b, id);
    bus.req_valid = 4'b0000;
    total++;
    if ({lat == 3, c, b, id} !== {1'b1, 4'd4, 1'b0, 2'd0}) begin
      bad++; $display("FAIL mid_after lat=%0d cnt=%0d bit=%0b id=%0d want lat=3 cnt=4 bit=0 id=0", lat, c, b, id);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_threshold();
    test_round_robin();
    test_stall();
    test_cfg_boundaries();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
